mode_selector: RTL and testbench



---
 rtl/led_anim_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 63 ++++++
 rtl/mode_selector.sv | 132 +++++++++++++
 tb/tb_mode_selector.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/led_anim_pkg.sv
// Shared definitions for the LED animation subsystem.
//
// Contents:
//   - Mode codes driven by mode_selector and decoded by the animation top.
//   - The mode_selector press-classification FSM state type.
//   - next_mode(): short-press mode advance with explicit 2 -> 0 wrap.
package led_anim_pkg;

  // Animation mode codes
  localparam logic [1:0] MODE_SHIFT = 2'd0;
  localparam logic [1:0] MODE_FILL  = 2'd1;
  localparam logic [1:0] MODE_PWM   = 2'd2;
  localparam logic [1:0] MODE_OFF   = 2'd3;

  // Press classifier states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShort = 2'd1,
    StLong  = 2'd2
  } sel_state_e;

  // Short press cycles the three active animations. Off is not part of the
  // ring: a short press from off restarts at shift, and 2 never steps to 3.
  function automatic logic [1:0] next_mode(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      MODE_SHIFT: nxt = MODE_FILL;
      MODE_FILL:  nxt = MODE_PWM;
      default:    nxt = MODE_SHIFT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter-based debouncer for a raw push button.
//
// Parameters:
//   CNT_W   width of the debounce counter
//   DB_CNT  consecutive stable synchronized cycles needed to accept a change
//           (legal 1 .. 2^CNT_W-1)
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   btn      in   raw button, asynchronous to clk, 1 = pressed
//   pressed  out  debounced, registered button level
//
// Latency from a stable btn change to pressed: 2 + DB_CNT clock edges.
module btn_debounce #(
  parameter int unsigned          CNT_W  = 8,
  parameter logic [CNT_W-1:0]     DB_CNT = 8'd16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pressed
);

  localparam logic [CNT_W-1:0] DbLast = DB_CNT - CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             btn_s;

  assign btn_s = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], btn};
    cnt_d     = '0;
    pressed_d = pressed_q;
    // Any cycle that agrees with the accepted level restarts the count, so a
    // glitch must persist DB_CNT cycles back-to-back to be taken.
    if (btn_s != pressed_q) begin
      if (cnt_q == DbLast) begin
        pressed_d = btn_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b00;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/mode_selector.sv
// Push-button mode selector for the LED animation top.
//
// Debounces a raw button and classifies presses: a short press advances the
// animation mode (shift -> fill -> PWM -> shift, off -> shift); a press held
// LONG_CNT debounced cycles forces the off mode.
//
// Parameters:
//   CNT_W     width of the debounce and hold counters
//   DB_CNT    debounce length in cycles (legal 1 .. 2^CNT_W-1)
//   LONG_CNT  debounced-pressed cycles that make a press long
//             (legal 1 .. 2^CNT_W-1)
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   btn           in   raw button, asynchronous, 1 = pressed
//   mode          out  [1:0] selected animation (0 shift, 1 fill, 2 PWM, 3 off)
//   mode_changed  out  one-cycle pulse in the cycle mode takes a new value
//   pressed       out  debounced button level
//
// All outputs are registered.
module mode_selector
  import led_anim_pkg::*;
#(
  parameter int unsigned      CNT_W    = 8,
  parameter logic [CNT_W-1:0] DB_CNT   = 8'd16,
  parameter logic [CNT_W-1:0] LONG_CNT = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic [1:0] mode,
  output logic       mode_changed,
  output logic       pressed
);

  localparam logic [CNT_W-1:0] LongLast = LONG_CNT - CNT_W'(1);

  logic             pressed_db;
  logic             pressed_dly_q;
  logic             fall_q, fall_d;
  logic             rise;
  logic [CNT_W-1:0] hold_q, hold_d;
  sel_state_e       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             mode_changed_q, mode_changed_d;

  btn_debounce #(
    .CNT_W  (CNT_W),
    .DB_CNT (DB_CNT)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .pressed (pressed_db)
  );

  // Press start is taken straight off the edge register so the hold count
  // begins the edge after pressed rises (off lands LONG_CNT+1 edges later).
  // Release is retimed through one more flop: a short-press update lands two
  // edges after pressed falls, and a release that meets the long threshold
  // in the same cycle is still seen as short.
  assign rise   = pressed_db & ~pressed_dly_q;
  assign fall_d = pressed_dly_q & ~pressed_db;

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    mode_d         = mode_q;
    mode_changed_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StShort;
          hold_d  = '0;
        end
      end

      StShort: begin
        hold_d = hold_q + CNT_W'(1);
        if (fall_q) begin
          // Release wins over a coincident long threshold
          mode_d         = next_mode(mode_q);
          mode_changed_d = 1'b1;
          state_d        = StIdle;
        end else if (hold_q == LongLast) begin
          mode_d         = MODE_OFF;
          mode_changed_d = (mode_q != MODE_OFF);
          state_d        = StLong;
        end
      end

      StLong: begin
        // Saturate so an arbitrarily long hold never wraps the count
        if (hold_q != '1) begin
          hold_d = hold_q + CNT_W'(1);
        end
        if (fall_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressed_dly_q  <= 1'b0;
      fall_q         <= 1'b0;
      hold_q         <= '0;
      state_q        <= StIdle;
      mode_q         <= MODE_SHIFT;
      mode_changed_q <= 1'b0;
    end else begin
      pressed_dly_q  <= pressed_db;
      fall_q         <= fall_d;
      hold_q         <= hold_d;
      state_q        <= state_d;
      mode_q         <= mode_d;
      mode_changed_q <= mode_changed_d;
    end
  end

  assign mode         = mode_q;
  assign mode_changed = mode_changed_q;
  assign pressed      = pressed_db;

endmodule

// File: tb/tb_mode_selector.sv
// Scoreboard bench for mode_selector (DB_CNT = 16, LONG_CNT = 64).
module tb_mode_selector;

  localparam int DbLat = 2 + 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic [1:0] mode;
  logic       mode_changed;
  logic       pressed;

  always #5 clk = ~clk;

  mode_selector #(
    .CNT_W    (8),
    .DB_CNT   (8'd16),
    .LONG_CNT (8'd64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .mode         (mode),
    .mode_changed (mode_changed),
    .pressed      (pressed)
  );

  // Expected mode update: new value, reference edge (pressed rise or fall)
  // and edge count from that reference to the mode_changed cycle.
  typedef struct {
    logic [1:0] mode;
    bit         from_rise;
    int         lat;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int last_rise_cyc = 0;
  int last_fall_cyc = 0;
  int n_rises       = 0;
  int btn_rise_cyc  = 0;
  int btn_fall_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_mode(input logic [1:0] m, input bit from_rise, input int lat);
    exp_t e;
    e.mode      = m;
    e.from_rise = from_rise;
    e.lat       = lat;
    sb.push_back(e);
  endtask

  task automatic press(input int hi, input int lo);
    btn          = 1'b1;
    btn_rise_cyc = cyc;
    tick(hi);
    btn          = 1'b0;
    btn_fall_cyc = cyc;
    tick(lo);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each pulse
  initial begin
    logic       prev_pressed;
    logic       prev_mc;
    logic [1:0] prev_mode;
    exp_t       e;
    prev_pressed = 1'b0;
    prev_mc      = 1'b0;
    prev_mode    = 2'd0;
    forever begin
      @(negedge clk);
      if (pressed !== prev_pressed) begin
        if (pressed) begin
          last_rise_cyc = cyc;
          n_rises++;
        end else begin
          last_fall_cyc = cyc;
        end
      end
      if (!rst) begin
        if (mode_changed) begin
          check("pulse_width", prev_mc, 0);
          check("pulse_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("mode_value", mode, e.mode);
            check("mode_latency",
                  cyc - (e.from_rise ? last_rise_cyc : last_fall_cyc), e.lat);
          end
        end
        if (mode !== prev_mode) check("change_pulse", mode_changed, 1);
      end
      prev_pressed = pressed;
      prev_mc      = mode_changed;
      prev_mode    = mode;
    end
  end

  initial begin
    int n0;
    int r;

    // Reset state
    rst = 1'b1;
    tick(3);
    check("rst_mode", mode, 0);
    check("rst_mode_changed", mode_changed, 0);
    check("rst_pressed", pressed, 0);
    rst = 1'b0;

    // Idle
    tick(100);
    check("idle_mode", mode, 0);
    check("idle_pressed", pressed, 0);
    check("idle_rises", n_rises, 0);

    // Glitches shorter than DB_CNT
    n0 = n_rises;
    press(10, 40);
    press(15, 40);
    check("glitch_rises", n_rises - n0, 0);
    check("glitch_mode", mode, 0);

    // Three short presses: 1, 2, 0
    expect_mode(2'd1, 1'b0, 2);
    press(30, 30);
    check("db_rise_lat", last_rise_cyc - btn_rise_cyc, DbLat);
    check("db_fall_lat", last_fall_cyc - btn_fall_cyc, DbLat);
    check("short1_mode", mode, 1);
    expect_mode(2'd2, 1'b0, 2);
    press(30, 30);
    check("short2_mode", mode, 2);
    expect_mode(2'd0, 1'b0, 2);
    press(30, 30);
    check("short3_mode", mode, 0);

    // Long press forces off, release does nothing, short press returns to 0
    expect_mode(2'd3, 1'b1, 65);
    press(200, 60);
    check("long_mode", mode, 3);
    expect_mode(2'd0, 1'b0, 2);
    press(30, 30);
    check("off_to_shift", mode, 0);

    // Release coinciding with hold count LONG_CNT-1: short press wins
    expect_mode(2'd1, 1'b0, 2);
    press(63, 30);
    check("tie_mode", mode, 1);

    // Long press to off, then a second long press while already off
    expect_mode(2'd3, 1'b1, 65);
    press(100, 40);
    check("long2_mode", mode, 3);
    press(100, 40);
    check("long_in_off_mode", mode, 3);

    // Reset mid-press with the button held
    btn = 1'b1;
    tick(40);
    check("pre_rst_pressed", pressed, 1);
    rst = 1'b1;
    #1;
    check("rst_async_mode", mode, 0);
    check("rst_async_pressed", pressed, 0);
    tick(3);
    rst = 1'b0;
    r   = cyc;
    expect_mode(2'd1, 1'b0, 2);
    tick(30);
    check("rst_rise_lat", last_rise_cyc - r, DbLat);
    check("held_mode", mode, 0);
    btn = 1'b0;
    tick(30);
    check("after_release_mode", mode, 1);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
